// File: rtl/decode_stage_ctrl.sv
// decode_stage_ctrl: fetch->decode pipeline register sequencing for the RAPID-X core
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_fetch_valid, i_dec_rs1, i_dec_rs2, i_dec_uses_rs2 : fetch/decode side
//   i_ex_load, i_ex_rd, i_ex_busy, i_redirect           : execute side
//   o_pc_en, o_dec_en, o_dec_flush, o_ex_bubble         : combinational pipeline controls
//   o_dec_valid, o_stall_count                          : registered slot validity and stall counter
module decode_stage_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_W = 5,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_fetch_valid,
  input  logic [REG_W-1:0] i_dec_rs1,
  input  logic [REG_W-1:0] i_dec_rs2,
  input  logic             i_dec_uses_rs2,
  input  logic             i_ex_load,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_busy,
  input  logic             i_redirect,
  output logic             o_pc_en,
  output logic             o_dec_en,
  output logic             o_dec_flush,
  output logic             o_ex_bubble,
  output logic             o_dec_valid,
  output logic [CNT_W-1:0] o_stall_count
);
  typedef enum logic {RUN, FLUSH} state_e;
  state_e state_q, state_d;
  logic [3:0] flush_cnt_q, flush_cnt_d;
  logic dec_valid_q, dec_valid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic lu_hazard;
  assign lu_hazard = dec_valid_q & i_ex_load & (i_ex_rd != '0) &
                     ((i_ex_rd == i_dec_rs1) | (i_dec_uses_rs2 & (i_ex_rd == i_dec_rs2)));
  always_comb begin
    state_d = state_q;
    flush_cnt_d = flush_cnt_q;
    o_pc_en = 1'b1;
    o_dec_en = 1'b0;
    o_dec_flush = 1'b0;
    o_ex_bubble = 1'b0;
    if (!i_reset) begin
      o_pc_en = 1'b0;
      o_dec_flush = 1'b1;
      o_ex_bubble = 1'b1;
    end else if (i_redirect) begin
      o_dec_flush = 1'b1;
      o_ex_bubble = 1'b1;
      state_d = FLUSH;
      flush_cnt_d = 4'(FLUSH_CYCLES);
    end else if (i_ex_busy) begin
      o_pc_en = 1'b0;
    end else if (state_q == FLUSH) begin
      o_dec_flush = 1'b1;
      o_ex_bubble = 1'b1;
      flush_cnt_d = flush_cnt_q - 4'd1;
      state_d = (flush_cnt_q == 4'd1) ? RUN : FLUSH;
    end else if (lu_hazard) begin
      o_pc_en = 1'b0;
      o_ex_bubble = 1'b1;
    end else begin
      o_dec_en = 1'b1;
      o_ex_bubble = ~dec_valid_q;
    end
  end
  // pc_en is low exactly on load-use and busy cycles, which are the counted stalls
  assign dec_valid_d = o_dec_flush ? 1'b0 : o_dec_en ? i_fetch_valid : dec_valid_q;
  assign stall_d = (!o_pc_en && stall_q != '1) ? stall_q + CNT_W'(1) : stall_q;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= RUN;
      flush_cnt_q <= 4'd0;
      dec_valid_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      flush_cnt_q <= flush_cnt_d;
      dec_valid_q <= dec_valid_d;
      stall_q <= stall_d;
    end
  end
  assign o_dec_valid = dec_valid_q;
  assign o_stall_count = stall_q;
endmodule

// File: tb/tb_decode_stage_ctrl.sv
// tb_decode_stage_ctrl: directed vectors with scoreboard for decode_stage_ctrl
module tb_decode_stage_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fv = 1'b0, u2 = 1'b0, ld = 1'b0, busy = 1'b0, rdr = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic pc_en, dec_en, dec_flush, ex_bubble, dec_valid;
  logic [7:0] stall_count;
  typedef struct packed {logic [4:0] e; logic [7:0] cnt;} exp_t;
  exp_t sb[$];
  string nq[$];
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  decode_stage_ctrl #(.FLUSH_CYCLES(2), .REG_W(5), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_fetch_valid(fv), .i_dec_rs1(rs1), .i_dec_rs2(rs2),
    .i_dec_uses_rs2(u2), .i_ex_load(ld), .i_ex_rd(rd), .i_ex_busy(busy), .i_redirect(rdr),
    .o_pc_en(pc_en), .o_dec_en(dec_en), .o_dec_flush(dec_flush), .o_ex_bubble(ex_bubble),
    .o_dec_valid(dec_valid), .o_stall_count(stall_count)
  );
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t x;
      string nm;
      logic [4:0] got;
      x = sb.pop_front();
      nm = nq.pop_front();
      got = {pc_en, dec_en, dec_flush, ex_bubble, dec_valid};
      n_vec++;
      if (got !== x.e || stall_count !== x.cnt) begin
        n_err++;
        $display("FAIL %s: got pc/de/fl/bb/v=%b cnt=%0d, expected %b cnt=%0d", nm, got, stall_count, x.e, x.cnt);
      end
    end
  end
  task automatic step(input logic f, input logic l, input logic b, input logic r,
                      input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                      input logic use2, input logic [4:0] e, input logic [7:0] cnt, input string nm);
    fv = f; ld = l; busy = b; rdr = r; rd = d; rs1 = s1; rs2 = s2; u2 = use2;
    sb.push_back('{e: e, cnt: cnt});
    nq.push_back(nm);
    @(posedge clk);
    #1;
  endtask
  initial begin
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 0, "reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++)
      step(1, 0, 0, 0, 0, 0, 0, 0, (i == 0) ? 5'b11010 : 5'b11001, 0, "steady");
    step(1, 1, 0, 0, 5, 5, 0, 0, 5'b00011, 0, "lu_rs1");
    step(1, 0, 0, 0, 5, 5, 0, 0, 5'b11001, 1, "lu_clear");
    step(1, 1, 0, 0, 0, 0, 0, 0, 5'b11001, 1, "lu_rd0");
    step(1, 1, 0, 0, 7, 3, 7, 1, 5'b00011, 1, "lu_rs2");
    step(1, 1, 0, 0, 7, 3, 7, 0, 5'b11001, 2, "lu_rs2_unused");
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 2, "fetch_invalid");
    step(1, 1, 0, 0, 5, 5, 0, 0, 5'b11010, 2, "lu_slot_invalid");
    step(1, 0, 0, 1, 0, 0, 0, 0, 5'b10111, 2, "redirect");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b10110, 2, "flush1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b10110, 2, "flush2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11010, 2, "run_after_flush");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 2, "run_valid");
    step(1, 0, 0, 1, 0, 0, 0, 0, 5'b10111, 2, "redirect_a");
    step(1, 0, 0, 1, 0, 0, 0, 0, 5'b10110, 2, "redirect_b");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b10110, 2, "reflush1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b10110, 2, "reflush2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11010, 2, "run_after_reflush");
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0, 0, 0, 0, 5'b00001, 8'(2 + i), "busy_run");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 6, "busy_done");
    step(1, 0, 0, 1, 0, 0, 0, 0, 5'b10111, 6, "redirect_c");
    step(1, 0, 1, 0, 0, 0, 0, 0, 5'b00000, 6, "busy_flush");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b10110, 7, "flush_frozen1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b10110, 7, "flush_frozen2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11010, 7, "run_c");
    step(1, 0, 1, 1, 0, 0, 0, 0, 5'b10111, 7, "redirect_busy");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b10110, 7, "rb_flush1");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b10110, 7, "rb_flush2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11010, 7, "rb_run");
    for (int i = 0; i < 300; i++)
      step(1, 0, 1, 0, 0, 0, 0, 0, 5'b00001, (7 + i > 255) ? 8'd255 : 8'(7 + i), "saturate");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11001, 255, "sat_hold");
    step(1, 0, 0, 1, 0, 0, 0, 0, 5'b10111, 255, "redirect_d");
    rst_n = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 0, "async_reset");
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b00110, 0, "reset_hold");
    rst_n = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 5'b11010, 0, "run_after_reset");
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
